lacc_mem_bridge: RTL and testbench
==================================

LACC_MEM_BRIDGE -- requirements
Module: lacc_mem_bridge

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2).
- MAX_OUTSTANDING, 4, maximum reads issued to memory and not yet answered (power of 2, >=1).

REQ-002 Clock and reset: one clock; reset is synchronous and active-high.

REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset.
- lacc_flush, in, 1, discard queued requests.
- lacc_data_valid, in, 1, accelerator request valid.
- lacc_data_ready, out, 1, request accepted.
- lacc_data_addr, in, 32, byte address.
- lacc_data_read, in, 1, 1 = read, 0 = write.
- lacc_data_wdata, in, 32, write data, LSB-aligned.
- lacc_data_size, in, 2, 0 = byte, 1 = half, 2 = word.
- lacc_drsp_valid, out, 1, read data valid.
- lacc_drsp_rdata, out, 32, read data, zero-extended.
- mem_req_valid, out, 1, memory request valid.
- mem_req_ready, in, 1, memory accepts request.
- mem_req_addr, out, 32, word address, bits [1:0] = 0.
- mem_req_we, out, 1, write enable.
- mem_req_wdata, out, 32, lane-positioned write data.
- mem_req_wstrb, out, 4, byte enables.
- mem_rsp_valid, in, 1, read response, in order, reads only.
- mem_rsp_rdata, in, 32, raw word.

Function
REQ-004 Request FIFO of REQ_DEPTH entries, each holding {addr, read, wdata, size}. lacc_data_ready = ~full. A push occurs on lacc_data_valid & lacc_data_ready.
REQ-005 A push into a full FIFO is never accepted, even when a pop occurs in the same cycle. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
REQ-006 Request path latency: a request pushed in cycle N into an empty FIFO drives mem_req_valid in cycle N+1; there is no combinational path from lacc_data_* to mem_req_*.
REQ-007 mem_req_valid = FIFO non-empty & ~(head is read & outstanding == MAX_OUTSTANDING). The head is popped on mem_req_valid & mem_req_ready. mem_req_* stay stable while valid and not ready.
REQ-008 mem_req_addr = {addr[31:2], 2'b00}. mem_req_we = ~read.
REQ-009 Write strobes and data lanes, with off = addr[1:0]:
- size 0: wstrb = 1 << off; wdata = wdata[7:0] replicated to all 4 lanes.
- size 1: wstrb = 4'b0011 << {off[1], 1'b0}; wdata = wdata[15:0] replicated to both halves; off[0] is ignored.
- size 2 or 3: wstrb = 4'b1111; off is ignored.
- For reads, wstrb = 0.
REQ-010 Read tracking FIFO of MAX_OUTSTANDING entries stores {off, size, drop} on each read pop. outstanding = its occupancy. A pop and a response in the same cycle leave the count unchanged.
REQ-011 On mem_rsp_valid, the tracking head is popped. If drop = 0: lacc_drsp_valid = 1 in the next cycle with rdata = (mem_rsp_rdata >> 8*off), masked to 8, 16 or 32 bits by size. If drop = 1: no lacc_drsp_valid.
REQ-012 lacc_drsp_valid is a single-cycle pulse per response and has no back-pressure.
REQ-013 mem_rsp_valid with an empty tracking FIFO is ignored; outstanding stays 0 and no pulse is generated.
REQ-014 lacc_flush (1 cycle) effects:
- Empties the request FIFO; a push in the same cycle is discarded.
- Sets drop = 1 on all tracking entries, including one popped in the same cycle.
- Leaves outstanding unchanged, so memory read responses still drain.
- A mem_req handshake in the flush cycle completes normally.
REQ-015 Pointer wrap-around for both FIFOs uses an extra direction bit; full = equal pointers with differing direction bits.

Reset
REQ-016 rst clears both FIFOs and the outstanding count. Outputs during and after reset: lacc_data_ready = 1 (from the first cycle after reset), lacc_drsp_valid = 0, lacc_drsp_rdata = 0, mem_req_valid = 0, mem_req_we = 0, mem_req_wstrb = 0.
REQ-017 Reset mid-transaction discards all queued and outstanding state; memory responses arriving after reset are ignored per REQ-013.
REQ-018 rst has priority over lacc_flush and over all handshakes.

Verification
REQ-019 Word read at 0x100, mem_req_ready = 1, response 0xDEADBEEF two cycles later -> mem_req_addr 0x100, we = 0, wstrb = 0; lacc_drsp_rdata 0xDEADBEEF one cycle after mem_rsp_valid.
REQ-020 Byte write of 0xA5 at 0x203 -> addr 0x200, wstrb 4'b1000, wdata 0xA5A5A5A5. Half read at 0x202 with raw 0x12345678 -> rdata 0x00001234.
REQ-021 Hold mem_req_ready = 0 and push 5 requests (REQ_DEPTH = 4) -> lacc_data_ready drops after the 4th push; the 5th is accepted only in the cycle after the first pop.
REQ-022 Issue 5 reads with no responses (MAX_OUTSTANDING = 4) -> exactly 4 memory handshakes and mem_req_valid held low; one response -> 5th read issued the next cycle.
REQ-023 Two reads outstanding, 2 queued, then lacc_flush -> request FIFO empty, no further mem_req; both memory responses consumed with no lacc_drsp_valid; a new read afterwards returns normally.
REQ-024 rst asserted with 3 queued and 2 outstanding -> all outputs at reset values next cycle; late mem_rsp_valid produces no lacc_drsp_valid.

Source files
------------

// File: rtl/lacc_mem_bridge_if.sv
// Signal bundle for the accelerator data port and the memory request/response port.
// The bridge takes the slave view; the accelerator/memory environment takes the master view.
interface lacc_mem_bridge_if;
    logic        lacc_flush;
    logic        lacc_data_valid;
    logic        lacc_data_ready;
    logic [31:0] lacc_data_addr;
    logic        lacc_data_read;
    logic [31:0] lacc_data_wdata;
    logic [1:0]  lacc_data_size;
    logic        lacc_drsp_valid;
    logic [31:0] lacc_drsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport slave (
        input  lacc_flush, lacc_data_valid, lacc_data_addr, lacc_data_read,
               lacc_data_wdata, lacc_data_size, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, mem_req_valid,
               mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb
    );

    modport master (
        output lacc_flush, lacc_data_valid, lacc_data_addr, lacc_data_read,
               lacc_data_wdata, lacc_data_size, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, mem_req_valid,
               mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb
    );
endinterface

// File: rtl/lacc_mem_bridge.sv
// Accelerator-to-memory bridge: queues byte/half/word requests, lane-positions writes,
// caps in-flight reads and realigns in-order read responses back to the accelerator.
module lacc_mem_bridge #(
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    lacc_mem_bridge_if.slave bus
);
    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int RPW = RAW + 1;
    localparam int TAW = $clog2(MAX_OUTSTANDING);
    localparam int TPW = TAW + 1;
    localparam int TIW = (TAW > 0) ? TAW : 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [1:0]  size;
    } req_t;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
    } trk_t;

    req_t                       req_q [REQ_DEPTH];
    req_t                       req_d [REQ_DEPTH];
    logic [RPW-1:0]             req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    trk_t                       trk_q [MAX_OUTSTANDING];
    trk_t                       trk_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] drop_q, drop_d;
    logic [TPW-1:0]             trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
    logic                       drsp_valid_q, drsp_valid_d;
    logic [31:0]                drsp_rdata_q, drsp_rdata_d;

    logic           req_empty, req_full, trk_empty, trk_full;
    logic [RAW-1:0] req_widx, req_ridx;
    logic [TIW-1:0] trk_widx, trk_ridx;
    req_t           head;
    trk_t           trk_head;
    logic           mem_valid, push, pop, trk_push, trk_pop;
    logic [31:0]    rsp_shift;

    always_comb begin
        req_widx  = req_wr_q[RAW-1:0];
        req_ridx  = req_rd_q[RAW-1:0];
        trk_widx  = TIW'(trk_wr_q) & TIW'(MAX_OUTSTANDING - 1);
        trk_ridx  = TIW'(trk_rd_q) & TIW'(MAX_OUTSTANDING - 1);
        head      = req_q[req_ridx];
        trk_head  = trk_q[trk_ridx];
        // Full when indices match but the wrap bits differ.
        req_empty = (req_wr_q == req_rd_q);
        req_full  = ((req_wr_q ^ req_rd_q) == RPW'(REQ_DEPTH));
        trk_empty = (trk_wr_q == trk_rd_q);
        trk_full  = ((trk_wr_q ^ trk_rd_q) == TPW'(MAX_OUTSTANDING));

        mem_valid = ~req_empty & ~(head.read & trk_full);
        push      = bus.lacc_data_valid & ~req_full & ~bus.lacc_flush;
        pop       = mem_valid & bus.mem_req_ready;
        trk_push  = pop & head.read;
        trk_pop   = bus.mem_rsp_valid & ~trk_empty;

        req_d = req_q;
        if (push) begin
            req_d[req_widx] = '{addr:  bus.lacc_data_addr,  read: bus.lacc_data_read,
                                wdata: bus.lacc_data_wdata, size: bus.lacc_data_size};
        end
        req_wr_d = req_wr_q + RPW'(push);
        req_rd_d = bus.lacc_flush ? req_wr_q : req_rd_q + RPW'(pop);

        trk_d  = trk_q;
        drop_d = drop_q;
        if (trk_push) begin
            trk_d[trk_widx]  = '{off: head.addr[1:0], size: head.size};
            drop_d[trk_widx] = bus.lacc_flush;
        end
        // Flush orphans every in-flight read; the responses still drain but are swallowed.
        if (bus.lacc_flush) drop_d = '1;
        trk_wr_d = trk_wr_q + TPW'(trk_push);
        trk_rd_d = trk_rd_q + TPW'(trk_pop);

        rsp_shift = bus.mem_rsp_rdata >> {trk_head.off, 3'b000};
        drsp_valid_d = trk_pop & ~drop_q[trk_ridx] & ~bus.lacc_flush;
        drsp_rdata_d = drsp_rdata_q;
        if (drsp_valid_d) begin
            case (trk_head.size)
                2'd0:    drsp_rdata_d = {24'b0, rsp_shift[7:0]};
                2'd1:    drsp_rdata_d = {16'b0, rsp_shift[15:0]};
                default: drsp_rdata_d = rsp_shift;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr_q     <= '0;
            req_rd_q     <= '0;
            trk_wr_q     <= '0;
            trk_rd_q     <= '0;
            drop_q       <= '0;
            drsp_valid_q <= 1'b0;
            drsp_rdata_q <= '0;
        end else begin
            req_q        <= req_d;
            req_wr_q     <= req_wr_d;
            req_rd_q     <= req_rd_d;
            trk_q        <= trk_d;
            drop_q       <= drop_d;
            trk_wr_q     <= trk_wr_d;
            trk_rd_q     <= trk_rd_d;
            drsp_valid_q <= drsp_valid_d;
            drsp_rdata_q <= drsp_rdata_d;
        end
    end

    assign bus.lacc_data_ready = ~req_full;
    assign bus.lacc_drsp_valid = drsp_valid_q;
    assign bus.lacc_drsp_rdata = drsp_rdata_q;
    assign bus.mem_req_valid   = mem_valid;
    assign bus.mem_req_addr    = {head.addr[31:2], 2'b00};
    assign bus.mem_req_we      = ~req_empty & ~head.read;

    always_comb begin
        bus.mem_req_wstrb = 4'b0000;
        bus.mem_req_wdata = head.wdata;
        if (~req_empty & ~head.read) begin
            case (head.size)
                2'd0: begin
                    bus.mem_req_wstrb = 4'b0001 << head.addr[1:0];
                    bus.mem_req_wdata = {4{head.wdata[7:0]}};
                end
                2'd1: begin
                    bus.mem_req_wstrb = 4'b0011 << {head.addr[1], 1'b0};
                    bus.mem_req_wdata = {2{head.wdata[15:0]}};
                end
                default: bus.mem_req_wstrb = 4'b1111;
            endcase
        end
    end
endmodule

// File: tb/tb_lacc_mem_bridge.sv
// Directed bench for lacc_mem_bridge: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares every memory handshake and read-data pulse.
module tb_lacc_mem_bridge;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          chk_wd;
    } mexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    mexp_t       mq[$];
    logic [31:0] rq[$];

    lacc_mem_bridge_if bus();

    lacc_mem_bridge #(.REQ_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [3:0] strb, input logic [31:0] lane,
                        input bit expect_issue);
        int n = 0;
        mexp_t e;
        bus.lacc_data_valid = 1'b1;
        bus.lacc_data_addr  = a;
        bus.lacc_data_read  = rd;
        bus.lacc_data_wdata = wd;
        bus.lacc_data_size  = sz;
        while (bus.lacc_data_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: addr %h never accepted, required acceptance", a);
        end
        if (expect_issue) begin
            e.addr = {a[31:2], 2'b00}; e.we = ~rd; e.wstrb = strb; e.wdata = lane; e.chk_wd = ~rd;
            mq.push_back(e);
        end
        tick();
        bus.lacc_data_valid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] raw, input logic [31:0] exp_rdata, input bit expect_pulse);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = raw;
        if (expect_pulse) rq.push_back(exp_rdata);
        tick();
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Monitor: every handshake and every pulse must match the head of its queue.
    always @(negedge clk) begin : monitor
        mexp_t e;
        if (rst !== 1'b1) begin
            if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
                if (mq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_req_unexpected: got addr %h, required no request", bus.mem_req_addr);
                end else begin
                    e = mq.pop_front();
                    chk("mem_req_addr", bus.mem_req_addr, e.addr);
                    chk("mem_req_we", 32'(bus.mem_req_we), 32'(e.we));
                    chk("mem_req_wstrb", 32'(bus.mem_req_wstrb), 32'(e.wstrb));
                    if (e.chk_wd) chk("mem_req_wdata", bus.mem_req_wdata, e.wdata);
                end
            end
            if (bus.lacc_drsp_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL drsp_unexpected: got rdata %h, required no pulse", bus.lacc_drsp_rdata);
                end else begin
                    chk("drsp_rdata", bus.lacc_drsp_rdata, rq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lacc_flush = 1'b0; bus.lacc_data_valid = 1'b0; bus.lacc_data_addr = '0;
        bus.lacc_data_read = 1'b0; bus.lacc_data_wdata = '0; bus.lacc_data_size = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_data_ready", 32'(bus.lacc_data_ready), 32'd1);
        chk("rst_drsp_valid", 32'(bus.lacc_drsp_valid), 32'd0);
        chk("rst_drsp_rdata", bus.lacc_drsp_rdata, 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_req_we), 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_req_wstrb), 32'd0);
        tick();
        rst = 1'b0;

        // Word read at 0x100: one-cycle request latency, response one cycle later
        bus.mem_req_ready = 1'b1;
        push(32'h100, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("req_latency_valid", 32'(bus.mem_req_valid), 32'd1);
        tick(); tick();
        rsp(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("rsp_latency_valid", 32'(bus.lacc_drsp_valid), 32'd1);
        tick();

        // Write lanes/strobes and read realignment
        push(32'h203, 1'b0, 32'h000000A5, 2'd0, 4'b1000, 32'hA5A5A5A5, 1'b1);
        push(32'h206, 1'b0, 32'h0000BEEF, 2'd1, 4'b1100, 32'hBEEFBEEF, 1'b1);
        push(32'h20B, 1'b0, 32'h11223344, 2'd2, 4'b1111, 32'h11223344, 1'b1);
        push(32'h001, 1'b0, 32'hFFFFFF5A, 2'd0, 4'b0010, 32'h5A5A5A5A, 1'b1);
        push(32'h202, 1'b1, 32'h0, 2'd1, 4'h0, 32'h0, 1'b1);
        tick();
        rsp(32'h12345678, 32'h00001234, 1'b1);
        push(32'h301, 1'b1, 32'h0, 2'd0, 4'h0, 32'h0, 1'b1);
        tick();
        rsp(32'hAABBCCDD, 32'h000000CC, 1'b1);
        tick(); tick();
        chk("lanes_mq_drained", mq.size(), 0);
        chk("lanes_rq_drained", rq.size(), 0);

        // Request FIFO full: 5th push waits for the cycle after the first pop
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h600 + 4 * i, 1'b0, 32'h100 + i, 2'd2, 4'hF, 32'h100 + i, 1'b1);
        @(negedge clk);
        chk("full_ready_low", 32'(bus.lacc_data_ready), 32'd0);
        mq.push_back('{32'h610, 1'b1, 4'hF, 32'h104, 1'b1});
        bus.lacc_data_valid = 1'b1; bus.lacc_data_addr = 32'h610; bus.lacc_data_read = 1'b0;
        bus.lacc_data_wdata = 32'h104; bus.lacc_data_size = 2'd2;
        tick();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ready", 32'(bus.lacc_data_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("after_pop_ready", 32'(bus.lacc_data_ready), 32'd1);
        tick();
        bus.lacc_data_valid = 1'b0;
        repeat (6) tick();
        chk("full_mq_drained", mq.size(), 0);

        // Outstanding cap: 4 reads issue, 5th waits for a response
        for (int i = 0; i < 5; i++)
            push(32'h400 + 4 * i, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        chk("cap_valid_low", 32'(bus.mem_req_valid), 32'd0);
        chk("cap_four_issued", mq.size(), 1);
        tick();
        rsp(32'h40000000, 32'h40000000, 1'b1);
        @(negedge clk);
        chk("cap_fifth_issued", 32'(bus.mem_req_valid), 32'd1);
        tick();
        for (int i = 1; i < 5; i++) rsp(32'h40000000 + i, 32'h40000000 + i, 1'b1);
        tick(); tick();
        chk("cap_mq_drained", mq.size(), 0);
        chk("cap_rq_drained", rq.size(), 0);

        // Flush with 2 outstanding and 2 queued
        bus.mem_req_ready = 1'b0;
        push(32'h900, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        push(32'h904, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        push(32'h908, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b0);
        push(32'h90C, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b0);
        bus.mem_req_ready = 1'b1;
        tick(); tick();
        bus.mem_req_ready = 1'b0;
        bus.lacc_flush = 1'b1;
        tick();
        bus.lacc_flush = 1'b0;
        bus.mem_req_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("flush_valid_low", 32'(bus.mem_req_valid), 32'd0);
        chk("flush_ready_high", 32'(bus.lacc_data_ready), 32'd1);
        chk("flush_mq_drained", mq.size(), 0);
        tick();
        rsp(32'h11111111, 32'h0, 1'b0);
        rsp(32'h22222222, 32'h0, 1'b0);
        push(32'h500, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        tick();
        rsp(32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
        tick(); tick();
        chk("flush_rq_drained", rq.size(), 0);

        // Reset with 3 queued and 2 outstanding
        bus.mem_req_ready = 1'b0;
        push(32'h700, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        push(32'h704, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        bus.mem_req_ready = 1'b1;
        tick(); tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(32'h780 + 4 * i, 1'b0, 32'h55, 2'd2, 4'hF, 32'h55, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data_ready", 32'(bus.lacc_data_ready), 32'd1);
        chk("mid_rst_drsp_valid", 32'(bus.lacc_drsp_valid), 32'd0);
        chk("mid_rst_drsp_rdata", bus.lacc_drsp_rdata, 32'd0);
        chk("mid_rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_req_we), 32'd0);
        chk("mid_rst_mem_wstrb", 32'(bus.mem_req_wstrb), 32'd0);
        tick();
        bus.mem_req_ready = 1'b1;
        rsp(32'h33333333, 32'h0, 1'b0);
        rsp(32'h44444444, 32'h0, 1'b0);
        tick(); tick();
        chk("post_rst_mq_drained", mq.size(), 0);
        chk("post_rst_rq_drained", rq.size(), 0);
        push(32'h800, 1'b1, 32'h0, 2'd2, 4'h0, 32'h0, 1'b1);
        tick();
        rsp(32'h0BADCAFE, 32'h0BADCAFE, 1'b1);
        tick(); tick();
        chk("final_rq_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
